// File: rtl/ppu_vram_arb_if.sv
// Bus bundle between the PPU VRAM arbiter and its clients: render fetch port,
// CPU register port and the single-port VRAM macro.
interface ppu_vram_arb_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);
  logic              ren_req;
  logic [ADDR_W-1:0] ren_addr;
  logic              ren_rdy;
  logic              ren_rvalid;
  logic [DATA_W-1:0] ren_rdata;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              vram_en;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_a;
  logic [DATA_W-1:0] vram_din;
  logic [DATA_W-1:0] vram_dout;
  logic              busy;

  modport slave (
    input  ren_req, ren_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_dout,
    output ren_rdy, ren_rvalid, ren_rdata, cpu_ack, cpu_rdata,
           vram_en, vram_we, vram_a, vram_din, busy
  );

  modport master (
    output ren_req, ren_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_dout,
    input  ren_rdy, ren_rvalid, ren_rdata, cpu_ack, cpu_rdata,
           vram_en, vram_we, vram_a, vram_din, busy
  );
endinterface

// File: rtl/ppu_vram_arb.sv
// PPU VRAM arbiter: render fetch has priority, CPU accesses get a slot after
// CPU_STARVE_MAX render grants. Define PPU_VRAM_ARB_RDBUF_EN for the $2007 read buffer.
module ppu_vram_arb #(
  parameter int ADDR_W         = 14,
  parameter int DATA_W         = 8,
  parameter int CPU_STARVE_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  ppu_vram_arb_if.slave    bus
);

  typedef enum logic [2:0] {
    C_IDLE, C_PEND, C_ISSUE, C_WAIT, C_ACK, C_DONE
  } cstate_t;

  localparam logic [3:0] STARVE_MAX = 4'(CPU_STARVE_MAX);

  cstate_t           state, state_nx;
  logic [3:0]        starve_cnt;
  logic              cpu_grant, ren_grant;
  logic [1:0]        vld_pipe, own_pipe;  // own: 1 = CPU read
  logic              cpu_ret;
  logic [DATA_W-1:0] cpu_fetch;
  logic              vram_en_q, vram_we_q, ren_rvalid_q;
  logic [ADDR_W-1:0] vram_a_q;
  logic [DATA_W-1:0] vram_din_q, ren_rdata_q, cpu_rdata_q;

  assign cpu_grant = (state == C_PEND) && (!bus.ren_req || starve_cnt == STARVE_MAX);
  assign ren_grant = bus.ren_req && !cpu_grant;

  // Gated by rst_n so the combinational ready also reads 0 while in reset.
  assign bus.ren_rdy    = ren_grant & rst_n;
  assign bus.ren_rvalid = ren_rvalid_q;
  assign bus.ren_rdata  = ren_rdata_q;
  assign bus.cpu_ack    = (state == C_ACK);
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.vram_en    = vram_en_q;
  assign bus.vram_we    = vram_we_q;
  assign bus.vram_a     = vram_a_q;
  assign bus.vram_din   = vram_din_q;
  assign bus.busy       = (state != C_IDLE);

  always_comb begin
    state_nx = state;
    unique case (state)
      C_IDLE:  if (bus.cpu_req) state_nx = C_PEND;
      C_PEND:  if (cpu_grant)   state_nx = C_ISSUE;
      C_ISSUE: state_nx = bus.cpu_we ? C_ACK : C_WAIT;
      C_WAIT:  if (cpu_ret)     state_nx = C_ACK;
      C_ACK:   state_nx = C_DONE;
      C_DONE:  if (!bus.cpu_req) state_nx = C_IDLE;
      default: state_nx = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= C_IDLE;
      starve_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state != C_PEND || cpu_grant)
        starve_cnt <= '0;
      else if (ren_grant && starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // VRAM request registers: address/data hold on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vram_en_q  <= 1'b0;
      vram_we_q  <= 1'b0;
      vram_a_q   <= '0;
      vram_din_q <= '0;
    end else begin
      vram_en_q <= cpu_grant | ren_grant;
      vram_we_q <= cpu_grant & bus.cpu_we;
      if (cpu_grant) begin
        vram_a_q   <= bus.cpu_addr;
        vram_din_q <= bus.cpu_wdata;
      end else if (ren_grant) begin
        vram_a_q   <= bus.ren_addr;
      end
    end
  end

  // Read tags follow the access: stage 1 lines up with vram_dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe     <= '0;
      own_pipe     <= '0;
      ren_rvalid_q <= 1'b0;
      ren_rdata_q  <= '0;
      cpu_ret      <= 1'b0;
      cpu_fetch    <= '0;
    end else begin
      vld_pipe     <= {vld_pipe[0], ren_grant | (cpu_grant & ~bus.cpu_we)};
      own_pipe     <= {own_pipe[0], cpu_grant};
      ren_rvalid_q <= vld_pipe[1] & ~own_pipe[1];
      cpu_ret      <= vld_pipe[1] & own_pipe[1];
      if (vld_pipe[1] && !own_pipe[1]) ren_rdata_q <= bus.vram_dout;
      if (vld_pipe[1] &&  own_pipe[1]) cpu_fetch   <= bus.vram_dout;
    end
  end

`ifdef PPU_VRAM_ARB_RDBUF_EN
  logic [DATA_W-1:0] rdbuf;
  logic              is_pal;

  // Palette space bypasses the buffer, but the buffer is still refilled.
  assign is_pal = ((bus.cpu_addr >> 8) == ADDR_W'(8'h3F));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdbuf       <= '0;
      cpu_rdata_q <= '0;
    end else if (state == C_WAIT && cpu_ret) begin
      rdbuf       <= cpu_fetch;
      cpu_rdata_q <= is_pal ? cpu_fetch : rdbuf;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cpu_rdata_q <= '0;
    else if (state == C_WAIT && cpu_ret)
      cpu_rdata_q <= cpu_fetch;
  end
`endif

endmodule

// File: tb/tb_ppu_vram_arb.sv
// Directed bench for ppu_vram_arb with a behavioural single-port VRAM model.
module tb_ppu_vram_arb;
  logic clk, rst_n;
  int   n_vec, n_err;

  ppu_vram_arb_if bus ();
  ppu_vram_arb dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0] mem [0:16383];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.vram_en) begin
      if (bus.vram_we) mem[bus.vram_a] <= bus.vram_din;
      else             bus.vram_dout   <= mem[bus.vram_a];
    end
  end

  function automatic logic [7:0] pat(int i);
    return 8'((i * 37) ^ (i >> 8) ^ 8'h5A);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full CPU transaction; lat = cycles from request to ack.
  task automatic cpu_access(input logic we, input logic [13:0] a, input logic [7:0] wd,
                            output logic [7:0] rd, output int lat);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = wd;
    lat = 0; rd = '0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (bus.cpu_ack) begin lat = n; rd = bus.cpu_rdata; break; end
    end
    if (lat == 0) chk("cpu_ack_timeout", 0, 1);
    bus.cpu_req = 1'b0;
    step(); step();
  endtask

  logic [7:0] rd;
  int         lat, acks, ens;
  logic [7:0] exp_starve_rd;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0;
    for (int i = 0; i < 16384; i++) mem[i] = pat(i);
    mem[14'h23C0] = 8'hA7;
    bus.ren_req = 0; bus.ren_addr = '0; bus.cpu_req = 0; bus.cpu_we = 0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_en",   bus.vram_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ack",  bus.cpu_ack, 0);
    chk("rst_rval", bus.ren_rvalid, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // CPU write, no render traffic
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 14'h2000; bus.cpu_wdata = 8'h5A;
    step();                                   // PEND, granted this cycle
    chk("wr_busy", bus.busy, 1);
    chk("wr_en_c1", bus.vram_en, 0);
    step();                                   // ISSUE
    chk("wr_en", bus.vram_en, 1);
    chk("wr_we", bus.vram_we, 1);
    chk("wr_a", bus.vram_a, 14'h2000);
    chk("wr_din", bus.vram_din, 8'h5A);
    chk("wr_ack_early", bus.cpu_ack, 0);
    step();                                   // ACK
    chk("wr_ack", bus.cpu_ack, 1);
    chk("wr_idle_en", bus.vram_en, 0);
    chk("wr_a_hold", bus.vram_a, 14'h2000);
    step();                                   // DONE
    chk("wr_ack_pulse", bus.cpu_ack, 0);
    chk("wr_busy_done", bus.busy, 1);
    bus.cpu_req = 0;
    step();
    chk("wr_busy_low", bus.busy, 0);
    chk("wr_mem", mem[14'h2000], 8'h5A);

    // CPU reads: buffered or direct depending on build
    mem[14'h2000] = 8'h11; mem[14'h2001] = 8'h22; mem[14'h3F01] = 8'h0F;
    cpu_access(0, 14'h2000, 8'h00, rd, lat);
    chk("rd0_lat", lat, 5);
`ifdef PPU_VRAM_ARB_RDBUF_EN
    chk("rd0_data", rd, 8'h00);
`else
    chk("rd0_data", rd, 8'h11);
`endif
    cpu_access(0, 14'h2001, 8'h00, rd, lat);
`ifdef PPU_VRAM_ARB_RDBUF_EN
    chk("rd1_data", rd, 8'h11);
`else
    chk("rd1_data", rd, 8'h22);
`endif
    cpu_access(0, 14'h3F01, 8'h00, rd, lat);
    chk("rd_pal_data", rd, 8'h0F);

    // Render streaming: full throughput, latency 3
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("str_rval%0d", k), bus.ren_rvalid, (k >= 3) ? 1 : 0);
      if (k >= 3) chk($sformatf("str_rdat%0d", k), bus.ren_rdata, pat(k - 3));
      bus.ren_req = (k < 12); bus.ren_addr = 14'(k);
      #1;
      chk($sformatf("str_rdy%0d", k), bus.ren_rdy, (k < 12) ? 1 : 0);
      step();
      if (k == 14) chk("str_drain", bus.ren_rvalid, 0);
    end

    // Starvation guard: 8 render grants, one CPU slot
`ifdef PPU_VRAM_ARB_RDBUF_EN
    exp_starve_rd = 8'h0F;
`else
    exp_starve_rd = 8'hA7;
`endif
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 14'h23C0;
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("stv_rval%0d", k), bus.ren_rvalid, (k >= 3 && k != 12) ? 1 : 0);
      if (k >= 3 && k != 12) chk($sformatf("stv_rdat%0d", k), bus.ren_rdata, pat(14'h100 + k - 3));
      chk($sformatf("stv_ack%0d", k), bus.cpu_ack, (k == 13) ? 1 : 0);
      if (k == 13) begin
        chk("stv_rdata", bus.cpu_rdata, exp_starve_rd);
        bus.cpu_req = 0;
      end
      bus.ren_req = 1; bus.ren_addr = 14'h100 + 14'(k);
      #1;
      chk($sformatf("stv_rdy%0d", k), bus.ren_rdy, (k != 9) ? 1 : 0);
      step();
    end
    bus.ren_req = 0;
    step(); step(); step(); step();
    chk("stv_idle", bus.busy, 0);

    // Request held past ack: exactly one access
    acks = 0; ens = 0;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 14'h0123; bus.cpu_wdata = 8'h77;
    for (int k = 0; k < 9; k++) begin
      acks += int'(bus.cpu_ack);
      ens  += int'(bus.vram_en);
      step();
    end
    chk("hold_acks", acks, 1);
    chk("hold_ens", ens, 1);
    chk("hold_mem", mem[14'h0123], 8'h77);
    bus.cpu_req = 0;
    step();
    chk("hold_busy_low", bus.busy, 0);
    bus.cpu_wdata = 8'h78;
    cpu_access(1, 14'h0123, 8'h78, rd, lat);
    chk("rereq_lat", lat, 3);
    chk("rereq_mem", mem[14'h0123], 8'h78);

    // Async reset in C_WAIT with render reads in flight
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 14'h2001;
    step();                                   // c1 PEND, grant
    bus.ren_req = 1; bus.ren_addr = 14'h0200;
    step();                                   // c2 ISSUE
    bus.ren_addr = 14'h0201;
    step();                                   // c3 WAIT
    bus.ren_addr = 14'h0202;
    step();                                   // c4 WAIT, returns pending
    chk("ar_pre_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_en",   bus.vram_en, 0);
    chk("ar_we",   bus.vram_we, 0);
    chk("ar_a",    bus.vram_a, 0);
    chk("ar_din",  bus.vram_din, 0);
    chk("ar_rdy",  bus.ren_rdy, 0);
    chk("ar_rval", bus.ren_rvalid, 0);
    chk("ar_rdat", bus.ren_rdata, 0);
    chk("ar_ack",  bus.cpu_ack, 0);
    chk("ar_crd",  bus.cpu_rdata, 0);
    chk("ar_busy", bus.busy, 0);
    bus.ren_req = 0; bus.cpu_req = 0;
    step(); step();
    rst_n = 1'b1;
    acks = 0; ens = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      acks += int'(bus.cpu_ack);
      ens  += int'(bus.ren_rvalid);
    end
    chk("ar_post_ack", acks, 0);
    chk("ar_post_rval", ens, 0);
    chk("ar_post_busy", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
